// File: rtl/mode_counter_core.sv
// mode_counter_core: WIDTH-bit counter driven by a one-hot mode select.
// Modes are binary up, binary down, Gray up and Johnson.
// Q, ModeQ and Err are registered. TC is decoded from the registered state and gated by En.
// Build option: define MODE_COUNTER_SYNC_CLR_EN to add a synchronous Clr input.
// Clr clears Q and the Gray binary shadow. ModeQ and Err are left as they are.
module mode_counter_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       D,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
`ifdef MODE_COUNTER_SYNC_CLR_EN
    input  logic             Clr,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [3:0]       ModeQ,
    output logic             TC,
    output logic             Err
);

    localparam logic [3:0] ModeUp   = 4'b0001;
    localparam logic [3:0] ModeDown = 4'b0010;
    localparam logic [3:0] ModeGray = 4'b0100;
    localparam logic [3:0] ModeJohn = 4'b1000;

    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MsbOnly = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;   // Binary shadow of the Gray count.
    logic [3:0]       r_mode;
    logic             r_err;

    logic [WIDTH-1:0] w_q_d;
    logic [WIDTH-1:0] w_b_d;
    logic [3:0]       w_mode_d;
    logic             w_err_d;
    logic             w_multi;
    logic [WIDTH-1:0] w_b_inc;
    logic             w_clr;

    // More than one bit set. D & (D-1) clears the lowest set bit.
    assign w_multi = (D & (D - 4'd1)) != 4'd0;
    assign w_b_inc = r_b + WIDTH'(1);

`ifdef MODE_COUNTER_SYNC_CLR_EN
    assign w_clr = Clr;
`else
    assign w_clr = 1'b0;
`endif

    // Next-state: D classification, then mode change, then clear, then load, then count.
    always_comb begin
        w_q_d    = r_q;
        w_b_d    = r_b;
        w_mode_d = r_mode;
        w_err_d  = r_err;
        if (w_multi) begin
            w_err_d = 1'b1;
        end else if (D == 4'd0) begin
            // Idle: the counter holds its value and resumes later in the same mode.
        end else if (D != r_mode) begin
            w_mode_d = D;
            w_q_d    = '0;
            w_b_d    = '0;
        end else if (w_clr) begin
            w_q_d = '0;
            w_b_d = '0;
        end else if (Load) begin
            unique case (r_mode)
                ModeGray: begin
                    w_b_d = Din;
                    w_q_d = Din ^ (Din >> 1);
                end
                default:  w_q_d = Din;
            endcase
        end else if (En) begin
            unique case (r_mode)
                ModeUp:   w_q_d = r_q + WIDTH'(1);
                ModeDown: w_q_d = r_q - WIDTH'(1);
                ModeGray: begin
                    w_b_d = w_b_inc;
                    w_q_d = w_b_inc ^ (w_b_inc >> 1);
                end
                ModeJohn: w_q_d = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
                default:  w_q_d = r_q;
            endcase
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q    <= '0;
            r_b    <= '0;
            r_mode <= ModeUp;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_d;
            r_b    <= w_b_d;
            r_mode <= w_mode_d;
            r_err  <= w_err_d;
        end
    end

    // Terminal count: high in the cycle before the wrapping edge, gated by En.
    always_comb begin
        TC = 1'b0;
        if (En) begin
            unique case (r_mode)
                ModeUp:   TC = (r_q == AllOnes);
                ModeDown: TC = (r_q == '0);
                ModeGray: TC = (r_b == AllOnes);
                ModeJohn: TC = (r_q == MsbOnly);
                default:  TC = 1'b0;
            endcase
        end
    end

    assign Q     = r_q;
    assign ModeQ = r_mode;
    assign Err   = r_err;

endmodule

// File: tb/tb_mode_counter_core.sv
// Self-checking bench for mode_counter_core with WIDTH=4.
// A reference model pushes the expected state for each edge, and the state is popped after that edge.
// The Clr tests are compiled only when MODE_COUNTER_SYNC_CLR_EN is defined.
module tb_mode_counter_core;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic       en;
    logic       ld;
    logic [3:0] din;
    logic       clr;
    logic [3:0] q;
    logic [3:0] modeq;
    logic       tc;
    logic       err;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] mode;
        logic       tc;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int mq, mb, mmode, merr;

    int gray_seq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int john_seq[8]  = '{1, 3, 7, 15, 14, 12, 8, 0};

    mode_counter_core #(.WIDTH(4)) dut (
        .Clk   (clk),
        .Reset (rst),
        .D     (d),
        .En    (en),
        .Load  (ld),
        .Din   (din),
`ifdef MODE_COUNTER_SYNC_CLR_EN
        .Clr   (clr),
`endif
        .Q     (q),
        .ModeQ (modeq),
        .TC    (tc),
        .Err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq = 0; mb = 0; mmode = 1; merr = 0;
    endtask

    // Compute the model's next state from the driven inputs.
    task automatic model_edge();
        exp_t e;
        if ($countones(d) >= 2) begin
            merr = 1;
        end else if (d == 4'd0) begin
        end else if (int'(d) != mmode) begin
            mmode = int'(d); mq = 0; mb = 0;
`ifdef MODE_COUNTER_SYNC_CLR_EN
        end else if (clr) begin
            mq = 0; mb = 0;
`endif
        end else if (ld) begin
            if (mmode == 4) begin
                mb = int'(din);
                mq = mb ^ (mb >> 1);
            end else begin
                mq = int'(din);
            end
        end else if (en) begin
            case (mmode)
                1: mq = (mq + 1) % 16;
                2: mq = (mq + 15) % 16;
                4: begin mb = (mb + 1) % 16; mq = mb ^ (mb >> 1); end
                8: mq = ((mq << 1) & 15) | ((~mq >> 3) & 1);
                default: ;
            endcase
        end
        e.q    = mq[3:0];
        e.mode = mmode[3:0];
        e.err  = merr[0];
        e.tc   = en && ((mmode == 1 && mq == 15) || (mmode == 2 && mq == 0) ||
                        (mmode == 4 && mb == 15) || (mmode == 8 && mq == 8));
        sb_q.push_back(e);
    endtask

    // Drive one edge's inputs at the falling edge, then check the outputs 1 ns after the rising edge.
    task automatic step(input logic [3:0] sd, input logic sen, input logic sld,
                        input logic [3:0] sdin);
        exp_t e;
        @(negedge clk);
        d = sd; en = sen; ld = sld; din = sdin;
        model_edge();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_eq("sb_q", int'(q), int'(e.q));
            check_eq("sb_mode", int'(modeq), int'(e.mode));
            check_eq("sb_tc", int'(tc), int'(e.tc));
            check_eq("sb_err", int'(err), int'(e.err));
        end
    endtask

    initial begin
        logic [3:0] prev;
        rst = 1'b1; d = 4'b0001; en = 1'b1; ld = 1'b0; din = 4'd0; clr = 1'b0;
        model_reset();
        #12;
        check_eq("rst_q", int'(q), 0);
        check_eq("rst_mode", int'(modeq), 1);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_tc", int'(tc), 0);
        @(negedge clk);
        rst = 1'b0; d = 4'd0;

        // Up mode: 17 edges.
        for (int i = 0; i < 17; i++) begin
            step(4'b0001, 1'b1, 1'b0, 4'd0);
            check_eq("up_q", int'(q), (i + 1) % 16);
        end

        // Down mode: the first edge changes the mode, then the count wraps below zero.
        step(4'b0010, 1'b1, 1'b0, 4'd0);
        check_eq("dn_chg_q", int'(q), 0);
        check_eq("dn_chg_tc", int'(tc), 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b1, 1'b0, 4'd0);
            check_eq("dn_q", int'(q), 15 - i);
        end

        // Gray mode.
        step(4'b0100, 1'b1, 1'b0, 4'd0);
        prev = q;
        for (int i = 0; i < 16; i++) begin
            step(4'b0100, 1'b1, 1'b0, 4'd0);
            check_eq("gray_q", int'(q), gray_seq[i]);
            check_eq("gray_hd", $countones(q ^ prev), 1);
            prev = q;
        end

        // Johnson mode.
        step(4'b1000, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step(4'b1000, 1'b1, 1'b0, 4'd0);
            check_eq("john_q", int'(q), john_seq[i]);
        end

        // Load, idle hold and sticky error in up mode.
        step(4'b0001, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b1, 1'b0, 4'd0);
        check_eq("pre_load_q", int'(q), 5);
        step(4'b0001, 1'b1, 1'b1, 4'd9);
        check_eq("load_q", int'(q), 9);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b0, 4'd0);
        check_eq("idle_q", int'(q), 9);
        check_eq("idle_err", int'(err), 0);
        step(4'b0011, 1'b1, 1'b0, 4'd0);
        check_eq("err_set", int'(err), 1);
        check_eq("err_q", int'(q), 9);
        step(4'b0001, 1'b0, 1'b0, 4'd0);
        check_eq("err_sticky", int'(err), 1);
        step(4'b0001, 1'b1, 1'b0, 4'd0);
        check_eq("resume_q", int'(q), 10);

        // Gray load.
        step(4'b0100, 1'b0, 1'b0, 4'd0);
        step(4'b0100, 1'b1, 1'b1, 4'd6);
        check_eq("gray_load_q", int'(q), 5);
        step(4'b0100, 1'b1, 1'b0, 4'd0);
        check_eq("gray_after_load", int'(q), 4);

        // Reset asserted asynchronously in Johnson mode.
        step(4'b1000, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step(4'b1000, 1'b1, 1'b0, 4'd0);
        check_eq("john_pre_rst", int'(q), 7);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_q", int'(q), 0);
        check_eq("arst_mode", int'(modeq), 1);
        check_eq("arst_err", int'(err), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; d = 4'd0;
        step(4'b0100, 1'b1, 1'b0, 4'd0);
        check_eq("post_rst_mode", int'(modeq), 4);

`ifdef MODE_COUNTER_SYNC_CLR_EN
        step(4'b0001, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b1, 1'b0, 4'd0);
        check_eq("pre_clr_q", int'(q), 12);
        clr = 1'b1;
        step(4'b0001, 1'b1, 1'b0, 4'd0);
        clr = 1'b0;
        check_eq("clr_q", int'(q), 0);
        check_eq("clr_mode", int'(modeq), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
